dma_cmd_queue: RTL and testbench
================================

DMA_CMD_QUEUE -- requirements
Module: dma_cmd_queue

Interface
REQ-001 Parameter BASE, default 'h0F0, bus address of register 0; the register window is BASE..BASE+4.
REQ-002 Parameter DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_  input  1  asynchronous, active-low reset.
REQ-005 addr  input  `BUS_ADDR_WIDTH  bus address from current bus owner.
REQ-006 idata  input  `DATA_WIDTH  write data from bus owner.
REQ-007 odata  output  `DATA_WIDTH  read data to bus owner.
REQ-008 rw_  input  1  1 = read, 0 = write.
REQ-009 cs_  input  1  active-low bus-cycle valid (bus granted).
REQ-010 dsaddr  output  `BUS_ADDR_WIDTH  DMA source address.
REQ-011 ddaddr  output  `BUS_ADDR_WIDTH  DMA destination address.
REQ-012 dmode  output  2  DMA transfer mode.
REQ-013 dreq_  output  1  active-low DMA start request.
REQ-014 eop_  input  1  active-low end-of-transfer from the DMA controller.

Function
REQ-015 Hit = cs_ low and addr within BASE..BASE+4; no hit means no register effect and odata = 0.
REQ-016 Write (hit, rw_ = 0) SHALL take effect at the next rising edge; read (hit, rw_ = 1) SHALL drive odata combinationally in the same cycle.
REQ-017 Register map:
  - BASE+0 SRC: staging source address, R/W.
  - BASE+1 DST: staging destination address, R/W.
  - BASE+2 MODE: staging mode [1:0], R/W; upper bits read 0.
  - BASE+3 write = PUSH {SRC, DST, MODE} into FIFO tail, data ignored; read = STATUS.
  - BASE+4 DONECNT: read = completed-transfer count, write = clear to 0.
REQ-018 STATUS SHALL be: bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[8:4] FIFO count, other bits 0.
REQ-019 PUSH when full SHALL drop the command, leave the FIFO unchanged and set overflow.
REQ-020 Overflow SHALL clear only on a STATUS write with idata[3] = 1 (write-1-to-clear).
  - A STATUS write is also a PUSH.
REQ-021 FSM states SHALL be IDLE, REQ, BUSY.
REQ-022 IDLE -> REQ when FIFO non-empty.
  - On that edge, pop the head into the dsaddr/ddaddr/dmode output registers.
REQ-023 In REQ, dreq_ SHALL be low for exactly one cycle.
  - Next state is always BUSY.
REQ-024 In BUSY, dreq_ SHALL be high and the FSM SHALL wait for eop_ low, sampled at the rising edge.
REQ-025 BUSY with eop_ low -> IDLE and DONECNT increments.
  - DONECNT is 16 bits and wraps FFFF -> 0.
  - If a DONECNT clear write and an increment occur in the same cycle, the result SHALL be 0 and the increment is lost.
REQ-026 eop_ low while in IDLE or REQ SHALL be ignored.
REQ-027 dsaddr/ddaddr/dmode SHALL stay stable from the pop edge until the next pop.
REQ-028 Minimum spacing between successive dreq_ pulses SHALL be 3 cycles: REQ, BUSY of at least one cycle, IDLE.
REQ-029 PUSH and pop on the same edge SHALL leave count unchanged, and the pushed entry SHALL be accepted even when full.
  - The pop frees a slot, so overflow is not set.
REQ-030 Staging registers SHALL be unaffected by PUSH and pop.
  - Repeated PUSH without rewriting enqueues identical commands.
REQ-031 FIFO read/write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-032 On reset_ low, asynchronously:
  - FSM -> IDLE, FIFO empty, overflow 0, DONECNT 0.
  - SRC/DST/MODE 0.
  - dsaddr/ddaddr/dmode 0, dreq_ = 1.
REQ-033 Reset during BUSY SHALL abandon the transfer without incrementing DONECNT.
  - A late eop_ after release SHALL be ignored (FSM in IDLE).

Verification
REQ-034 Single command: write SRC=0x010, DST=0x080, MODE=2, PUSH -> edge after push: pop; next cycle dreq_ low for 1 cycle, dsaddr=0x010, ddaddr=0x080, dmode=2; STATUS busy=1; eop_ low 1 cycle -> IDLE, DONECNT=1.
REQ-035 Fill and overflow: DEPTH=4, eop_ held high, 6 PUSHes -> first pops into BUSY; count reaches 4, full=1; 6th push dropped, overflow=1; STATUS write idata=8 -> overflow=0, and that write's push is also dropped while full.
REQ-036 Simultaneous push/pop: count=DEPTH, FSM IDLE after eop_, PUSH on the pop edge -> count stays DEPTH, overflow stays 0.
REQ-037 Back-to-back drain: queue 3 distinct commands, eop_ pulsed 1 cycle after each dreq_ -> 3 dreq_ pulses in FIFO order, each spaced at least 3 cycles; DONECNT=3; empty=1.
REQ-038 Reset mid-transfer: reset_ low in BUSY with 2 queued -> all outputs at reset values, count=0; eop_ pulse after release -> DONECNT stays 0.
REQ-039 Decode: cs_ high or addr=BASE+5 with writes -> no register change, odata=0; DONECNT clear coincident with eop_ -> DONECNT=0.

Source files
------------

// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: bus-programmable command FIFO that feeds a DMA controller.
// Software stages SRC/DST/MODE and pushes them; the FSM pops one command at a
// time, pulses dreq_ low for one cycle and waits for eop_ before the next one.

`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module dma_cmd_queue #(
  parameter logic [`BUS_ADDR_WIDTH-1:0] BASE  = 'h0F0,
  parameter int                         DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic [`BUS_ADDR_WIDTH-1:0] addr,
  input  logic [`DATA_WIDTH-1:0]     idata,
  output logic [`DATA_WIDTH-1:0]     odata,
  input  logic                       rw_,
  input  logic                       cs_,
  output logic [`BUS_ADDR_WIDTH-1:0] dsaddr,
  output logic [`BUS_ADDR_WIDTH-1:0] ddaddr,
  output logic [1:0]                 dmode,
  output logic                       dreq_,
  input  logic                       eop_
);

  localparam int AW = `BUS_ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] dsaddr_q, dsaddr_d, ddaddr_q, ddaddr_d;
  logic [1:0]    dmode_q, dmode_d;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   doneCnt_q, doneCnt_d;

  logic [AW-1:0] srcMem  [DEPTH];
  logic [AW-1:0] dstMem  [DEPTH];
  logic [1:0]    modeMem [DEPTH];

  logic [AW-1:0] addrOff;
  logic [2:0]    regSel;
  logic          hit, wrEn, rdEn;
  logic          popEn, pushReq, pushAccept;
  logic [DW-1:0] statusVal;

  // A pop frees a slot on the same edge, so a push into a full FIFO is only
  // refused when no pop happens alongside it.
  assign addrOff    = addr - BASE;
  assign hit        = !cs_ && (addr >= BASE) && (addrOff <= AW'(4));
  assign regSel     = addrOff[2:0];
  assign wrEn       = hit && !rw_;
  assign rdEn       = hit && rw_;
  assign popEn      = (state_q == S_IDLE) && (count_q != '0);
  assign pushReq    = wrEn && (regSel == 3'd3);
  assign pushAccept = pushReq && ((count_q != FULL_CNT) || popEn);

  assign dsaddr = dsaddr_q;
  assign ddaddr = ddaddr_q;
  assign dmode  = dmode_q;
  assign dreq_  = (state_q != S_REQ);

  // Next-state logic for staging registers, FIFO bookkeeping, FSM and counters.
  always_comb begin
    src_d      = src_q;
    dst_d      = dst_q;
    mode_d     = mode_q;
    dsaddr_d   = dsaddr_q;
    ddaddr_d   = ddaddr_q;
    dmode_d    = dmode_q;
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    doneCnt_d  = doneCnt_q;

    if (wrEn && regSel == 3'd0) src_d  = idata[AW-1:0];
    if (wrEn && regSel == 3'd1) dst_d  = idata[AW-1:0];
    if (wrEn && regSel == 3'd2) mode_d = idata[1:0];

    if (pushReq && !pushAccept) overflow_d = 1'b1;
    if (pushReq && idata[3])    overflow_d = 1'b0;

    if (pushAccept) wptr_d = wptr_q + PW'(1);
    if (popEn) begin
      rptr_d   = rptr_q + PW'(1);
      dsaddr_d = srcMem[rptr_q];
      ddaddr_d = dstMem[rptr_q];
      dmode_d  = modeMem[rptr_q];
    end

    case ({pushAccept, popEn})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE:  if (popEn) state_d = S_REQ;
      S_REQ:   state_d = S_BUSY;
      S_BUSY:  if (!eop_) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_BUSY && !eop_) doneCnt_d = doneCnt_q + 16'd1;
    if (wrEn && regSel == 3'd4)     doneCnt_d = '0;
  end

  // All control state, cleared asynchronously so a reset abandons any transfer.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      src_q      <= '0;
      dst_q      <= '0;
      mode_q     <= '0;
      dsaddr_q   <= '0;
      ddaddr_q   <= '0;
      dmode_q    <= '0;
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      doneCnt_q  <= '0;
    end else begin
      src_q      <= src_d;
      dst_q      <= dst_d;
      mode_q     <= mode_d;
      dsaddr_q   <= dsaddr_d;
      ddaddr_q   <= ddaddr_d;
      dmode_q    <= dmode_d;
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      doneCnt_q  <= doneCnt_d;
    end
  end

  // FIFO storage needs no reset; entries are only read once count says valid.
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      srcMem[wptr_q]  <= src_q;
      dstMem[wptr_q]  <= dst_q;
      modeMem[wptr_q] <= mode_q;
    end
  end

  // Combinational read mux; anything but a read hit returns zero.
  always_comb begin
    statusVal      = '0;
    statusVal[0]   = (count_q == '0);
    statusVal[1]   = (count_q == FULL_CNT);
    statusVal[2]   = (state_q != S_IDLE);
    statusVal[3]   = overflow_q;
    statusVal[8:4] = 5'(count_q);
    odata = '0;
    if (rdEn) begin
      case (regSel)
        3'd0:    odata = DW'(src_q);
        3'd1:    odata = DW'(dst_q);
        3'd2:    odata = DW'(mode_q);
        3'd3:    odata = statusVal;
        3'd4:    odata = DW'(doneCnt_q);
        default: odata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb_dma_cmd_queue: directed checks of the DMA command queue with
// hand-computed expected register and output values.

`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_dma_cmd_queue;

  localparam logic [15:0] BASE = 16'h00F0;

  logic        clk = 1'b0;
  logic        reset_;
  logic [15:0] addr;
  logic [15:0] idata;
  logic [15:0] odata;
  logic        rw_;
  logic        cs_;
  logic [15:0] dsaddr;
  logic [15:0] ddaddr;
  logic [1:0]  dmode;
  logic        dreq_;
  logic        eop_;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;

  logic [15:0] pSrc[$];
  logic [15:0] pDst[$];
  logic [1:0]  pMode[$];
  int          pCyc[$];

  dma_cmd_queue #(.BASE(BASE), .DEPTH(4)) dut (
    .clk(clk), .reset_(reset_), .addr(addr), .idata(idata), .odata(odata),
    .rw_(rw_), .cs_(cs_), .dsaddr(dsaddr), .ddaddr(ddaddr), .dmode(dmode),
    .dreq_(dreq_), .eop_(eop_)
  );

  // Free-running clock with a 20 ns period.
  always #10 clk = ~clk;

  // Cycle counter used to measure spacing between dreq_ pulses.
  always @(posedge clk) cycleCount++;

  // Record every cycle in which dreq_ is low, along with the command outputs.
  always @(negedge clk) begin
    if (reset_ && !dreq_) begin
      pSrc.push_back(dsaddr);
      pDst.push_back(ddaddr);
      pMode.push_back(dmode);
      pCyc.push_back(cycleCount);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    idata = d;
    rw_   = 1'b0;
    cs_   = 1'b0;
    tick();
    cs_   = 1'b1;
    rw_   = 1'b1;
  endtask

  task automatic readReg(input logic [15:0] a, output logic [15:0] v);
    addr = a;
    rw_  = 1'b1;
    cs_  = 1'b0;
    #1;
    v    = odata;
    cs_  = 1'b1;
  endtask

  task automatic doReset();
    reset_ = 1'b0;
    #3;
    reset_ = 1'b1;
    tick();
  endtask

  task automatic stageCmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] m);
    applyStimulus(BASE + 16'd0, s);
    applyStimulus(BASE + 16'd1, d);
    applyStimulus(BASE + 16'd2, m);
  endtask

  initial begin
    logic [15:0] v;
    int base;
    int seen;

    reset_ = 1'b1;
    addr   = '0;
    idata  = '0;
    rw_    = 1'b1;
    cs_    = 1'b1;
    eop_   = 1'b1;

    // Single command end to end
    doReset();
    checkOutput("rst_dreq", dreq_, 1);
    checkOutput("rst_dsaddr", dsaddr, 0);
    readReg(BASE + 16'd3, v); checkOutput("rst_status", v, 16'h0001);
    readReg(BASE + 16'd4, v); checkOutput("rst_done", v, 0);
    stageCmd(16'h0010, 16'h0080, 16'd2);
    readReg(BASE + 16'd2, v); checkOutput("mode_rd", v, 2);
    applyStimulus(BASE + 16'd3, 16'h0000);
    readReg(BASE + 16'd3, v); checkOutput("s1_status_push", v, 16'h0010);
    checkOutput("s1_dreq_pre", dreq_, 1);
    tick();
    checkOutput("s1_dreq_low", dreq_, 0);
    checkOutput("s1_dsaddr", dsaddr, 16'h0010);
    checkOutput("s1_ddaddr", ddaddr, 16'h0080);
    checkOutput("s1_dmode", dmode, 2);
    readReg(BASE + 16'd3, v); checkOutput("s1_status_busy", v, 16'h0005);
    tick();
    checkOutput("s1_dreq_busy", dreq_, 1);
    eop_ = 1'b0;
    tick();
    eop_ = 1'b1;
    readReg(BASE + 16'd3, v); checkOutput("s1_status_idle", v, 16'h0001);
    readReg(BASE + 16'd4, v); checkOutput("s1_done", v, 1);
    checkOutput("s1_dsaddr_hold", dsaddr, 16'h0010);

    // Fill, overflow, write-1-to-clear, then push coinciding with pop
    doReset();
    stageCmd(16'h0111, 16'h0222, 16'd1);
    applyStimulus(BASE + 16'd3, 0); readReg(BASE + 16'd3, v); checkOutput("fill1", v, 16'h0010);
    applyStimulus(BASE + 16'd3, 0); readReg(BASE + 16'd3, v); checkOutput("fill2", v, 16'h0014);
    applyStimulus(BASE + 16'd3, 0); readReg(BASE + 16'd3, v); checkOutput("fill3", v, 16'h0024);
    applyStimulus(BASE + 16'd3, 0); readReg(BASE + 16'd3, v); checkOutput("fill4", v, 16'h0034);
    applyStimulus(BASE + 16'd3, 0); readReg(BASE + 16'd3, v); checkOutput("fill5_full", v, 16'h0046);
    applyStimulus(BASE + 16'd3, 0); readReg(BASE + 16'd3, v); checkOutput("fill6_ovf", v, 16'h004E);
    applyStimulus(BASE + 16'd3, 16'h0004); readReg(BASE + 16'd3, v); checkOutput("ovf_sticky", v, 16'h004E);
    applyStimulus(BASE + 16'd3, 16'h0008); readReg(BASE + 16'd3, v); checkOutput("ovf_clear", v, 16'h0046);
    readReg(BASE + 16'd0, v); checkOutput("staging_kept", v, 16'h0111);
    eop_ = 1'b0;
    tick();
    eop_ = 1'b1;
    readReg(BASE + 16'd3, v); checkOutput("full_idle", v, 16'h0042);
    applyStimulus(BASE + 16'd3, 0);
    readReg(BASE + 16'd3, v); checkOutput("pushpop_full", v, 16'h0046);
    checkOutput("pushpop_dreq", dreq_, 0);
    readReg(BASE + 16'd4, v); checkOutput("pushpop_done", v, 1);

    // Back-to-back drain of three distinct commands
    doReset();
    base = pSrc.size();
    stageCmd(16'h0100, 16'h0200, 16'd0); applyStimulus(BASE + 16'd3, 0);
    stageCmd(16'h0101, 16'h0201, 16'd1); applyStimulus(BASE + 16'd3, 0);
    stageCmd(16'h0102, 16'h0202, 16'd3); applyStimulus(BASE + 16'd3, 0);
    readReg(BASE + 16'd3, v); checkOutput("drain_start", v, 16'h0024);
    eop_ = 1'b0;
    tick();
    eop_ = 1'b1;
    seen = 1;
    for (int t = 0; t < 40 && seen < 3; t++) begin
      tick();
      if (!dreq_) begin
        tick();
        eop_ = 1'b0;
        tick();
        eop_ = 1'b1;
        seen++;
      end
    end
    checkOutput("drain_seen", seen, 3);
    checkOutput("drain_pulses", pSrc.size() - base, 3);
    if (pSrc.size() - base == 3) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("drain_src%0d", k), pSrc[base + k], 16'h0100 + 16'(k));
        checkOutput($sformatf("drain_dst%0d", k), pDst[base + k], 16'h0200 + 16'(k));
        checkOutput($sformatf("drain_mode%0d", k), pMode[base + k], (k == 2) ? 3 : k);
      end
      checkOutput("drain_gap01", (pCyc[base + 1] - pCyc[base]) >= 3, 1);
      checkOutput("drain_gap12", (pCyc[base + 2] - pCyc[base + 1]) >= 3, 1);
    end
    readReg(BASE + 16'd4, v); checkOutput("drain_done", v, 3);
    readReg(BASE + 16'd3, v); checkOutput("drain_empty", v, 16'h0001);

    // Reset in the middle of a transfer
    doReset();
    stageCmd(16'h0300, 16'h0400, 16'd1);
    applyStimulus(BASE + 16'd3, 0);
    applyStimulus(BASE + 16'd3, 0);
    applyStimulus(BASE + 16'd3, 0);
    readReg(BASE + 16'd3, v); checkOutput("mid_busy", v, 16'h0024);
    checkOutput("mid_dsaddr", dsaddr, 16'h0300);
    reset_ = 1'b0;
    #2;
    checkOutput("mid_rst_dreq", dreq_, 1);
    checkOutput("mid_rst_dsaddr", dsaddr, 0);
    checkOutput("mid_rst_ddaddr", ddaddr, 0);
    checkOutput("mid_rst_dmode", dmode, 0);
    readReg(BASE + 16'd3, v); checkOutput("mid_rst_status", v, 16'h0001);
    readReg(BASE + 16'd0, v); checkOutput("mid_rst_src", v, 0);
    reset_ = 1'b1;
    tick();
    eop_ = 1'b0;
    tick();
    eop_ = 1'b1;
    tick();
    readReg(BASE + 16'd4, v); checkOutput("late_eop_done", v, 0);
    readReg(BASE + 16'd3, v); checkOutput("late_eop_status", v, 16'h0001);
    checkOutput("late_eop_dreq", dreq_, 1);

    // Address decode and DONECNT clear racing an increment
    doReset();
    applyStimulus(BASE + 16'd0, 16'h00AA);
    addr  = BASE;
    idata = 16'h0555;
    rw_   = 1'b0;
    cs_   = 1'b1;
    tick();
    rw_   = 1'b1;
    #1;
    checkOutput("cs_high_odata", odata, 0);
    readReg(BASE + 16'd0, v); checkOutput("cs_high_src", v, 16'h00AA);
    applyStimulus(BASE + 16'd5, 16'h0777);
    readReg(BASE + 16'd5, v); checkOutput("oob_odata", v, 0);
    readReg(BASE - 16'd1, v); checkOutput("below_odata", v, 0);
    readReg(BASE + 16'd1, v); checkOutput("oob_dst", v, 0);
    readReg(BASE + 16'd3, v); checkOutput("oob_status", v, 16'h0001);
    applyStimulus(BASE + 16'd2, 16'hFFFF);
    readReg(BASE + 16'd2, v); checkOutput("mode_upper", v, 3);
    applyStimulus(BASE + 16'd3, 0);
    tick();
    tick();
    eop_ = 1'b0;
    tick();
    eop_ = 1'b1;
    readReg(BASE + 16'd4, v); checkOutput("dec_done1", v, 1);
    applyStimulus(BASE + 16'd3, 0);
    tick();
    tick();
    eop_ = 1'b0;
    applyStimulus(BASE + 16'd4, 0);
    eop_ = 1'b1;
    readReg(BASE + 16'd4, v); checkOutput("clr_vs_inc", v, 0);
    readReg(BASE + 16'd3, v); checkOutput("clr_vs_inc_idle", v, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard time limit so the run always ends even if the design hangs the bench.
  initial begin
    #200000;
    testsFailed++;
    $display("[TB] FAIL timeout: got 0x0 expected 0x1");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
